// File: rtl/ebpc_pkg.sv
// Shared EBPC types and constants: block layout, BPC code widths, code prefixes and lengths.
// Consumed by the bit-plane coder and its code selector.
package ebpc_pkg;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int DATA_W      = 8;
    localparam int BLOCK_SIZE  = 8;
    localparam int PLANE_W     = BLOCK_SIZE - 1;
    localparam int BPC_POS_W   = $clog2(BLOCK_SIZE - 1);
    localparam int BPC_RUN_W   = $clog2(DATA_W);
    localparam int BPC_CODE_W  = max_int(max_int(DATA_W, BLOCK_SIZE),
                                         max_int(5 + BPC_POS_W, 2 + BPC_RUN_W));
    localparam int BPC_LEN_W   = $clog2(BPC_CODE_W + 1);
    localparam int PLANE_IDX_W = $clog2(DATA_W + 1);
    localparam int RUN_CNT_W   = $clog2(DATA_W + 2);
    localparam int ONES_W      = $clog2(PLANE_W + 1);

    localparam logic [4:0] PFX_ALL_ONES = 5'b00000;
    localparam logic [4:0] PFX_DBP_ZERO = 5'b00001;
    localparam logic [4:0] PFX_TWO_ONES = 5'b00010;
    localparam logic [4:0] PFX_SINGLE   = 5'b00011;
    localparam logic [1:0] PFX_RUN      = 2'b01;
    localparam logic [2:0] PFX_ZERO1    = 3'b001;
    localparam logic       PFX_RAW      = 1'b1;

    localparam logic [BPC_LEN_W-1:0] LEN_BASE   = BPC_LEN_W'(DATA_W);
    localparam logic [BPC_LEN_W-1:0] LEN_PREFIX = BPC_LEN_W'(5);
    localparam logic [BPC_LEN_W-1:0] LEN_POS    = BPC_LEN_W'(5 + BPC_POS_W);
    localparam logic [BPC_LEN_W-1:0] LEN_RAW    = BPC_LEN_W'(PLANE_W + 1);
    localparam logic [BPC_LEN_W-1:0] LEN_RUN    = BPC_LEN_W'(2 + BPC_RUN_W);
    localparam logic [BPC_LEN_W-1:0] LEN_ZERO1  = BPC_LEN_W'(3);

    typedef struct packed {
        logic [DATA_W-1:0]              base;
        logic [0:DATA_W][PLANE_W-1:0]   dbp;
    } dbp_block_t;

    typedef struct packed {
        logic [BPC_CODE_W-1:0] data;
        logic [BPC_LEN_W-1:0]  len;
    } bpc_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BASE,
        ST_SCAN,
        ST_RUN
    } bpc_state_e;

endpackage

// File: rtl/bpc_coder_if.sv
// Downstream code stream from the bit-plane coder to the bit packer.
// The master drives code words and flush; the slave returns ready.
interface bpc_coder_if;
    import ebpc_pkg::*;

    logic [BPC_CODE_W-1:0] data;
    logic [BPC_LEN_W-1:0]  len;
    logic                  vld;
    logic                  rdy;
    logic                  flush;

    modport master (output data, len, vld, flush, input rdy);
    modport slave  (input data, len, vld, flush, output rdy);
endinterface

// File: rtl/bpc_code_sel.sv
// Combinational BPC code selection for one XOR bit-plane and for the pending zero run.
// EBPC_SINGLE_ZERO_CODE_EN selects the dedicated 3-bit code for a lone zero plane.
module bpc_code_sel
    import ebpc_pkg::*;
(
    input  logic [PLANE_W-1:0]   dbx,
    input  logic [PLANE_W-1:0]   dbp,
    input  logic [RUN_CNT_W-1:0] run,
    output bpc_code_t            plane_code,
    output bpc_code_t            run_code
);

    logic [BPC_POS_W-1:0] low_pos;
    logic [ONES_W-1:0]    ones;
    logic                 adjacent;
    logic [BPC_RUN_W-1:0] run_field;

    // Lowest set bit doubles as the position of a single one and the lower bit of an adjacent pair.
    always_comb begin
        low_pos = '0;
        ones    = '0;
        for (int b = PLANE_W - 1; b >= 0; b--) begin
            if (dbx[b]) begin
                low_pos = BPC_POS_W'(b);
            end
        end
        for (int b = 0; b < PLANE_W; b++) begin
            ones = ones + ONES_W'(dbx[b]);
        end
        adjacent = (dbx & (dbx >> 1)) != '0;
    end

    always_comb begin
        plane_code = '0;
        if (dbx == '1) begin
            plane_code.data = BPC_CODE_W'(PFX_ALL_ONES);
            plane_code.len  = LEN_PREFIX;
        end else if (dbp == '0) begin
            plane_code.data = BPC_CODE_W'(PFX_DBP_ZERO);
            plane_code.len  = LEN_PREFIX;
        end else if (ones == ONES_W'(2) && adjacent) begin
            plane_code.data = BPC_CODE_W'({PFX_TWO_ONES, low_pos});
            plane_code.len  = LEN_POS;
        end else if (ones == ONES_W'(1)) begin
            plane_code.data = BPC_CODE_W'({PFX_SINGLE, low_pos});
            plane_code.len  = LEN_POS;
        end else begin
            plane_code.data = BPC_CODE_W'({PFX_RAW, dbx});
            plane_code.len  = LEN_RAW;
        end
    end

    // Field is k-2; a lone zero plane without the dedicated code falls back to field 0.
    always_comb begin
        run_field = (run > RUN_CNT_W'(1)) ? BPC_RUN_W'(run - RUN_CNT_W'(2)) : '0;
        run_code  = '0;
`ifdef EBPC_SINGLE_ZERO_CODE_EN
        if (run == RUN_CNT_W'(1)) begin
            run_code.data = BPC_CODE_W'(PFX_ZERO1);
            run_code.len  = LEN_ZERO1;
        end else begin
            run_code.data = BPC_CODE_W'({PFX_RUN, run_field});
            run_code.len  = LEN_RUN;
        end
`else
        run_code.data = BPC_CODE_W'({PFX_RUN, run_field});
        run_code.len  = LEN_RUN;
`endif
    end

endmodule

// File: rtl/bpc_coder.sv
// EBPC bit-plane coder: latches one delta bit-plane block, emits the base then one code per plane or zero run.
// Build option EBPC_SINGLE_ZERO_CODE_EN enables the 3-bit single-zero-plane code.
module bpc_coder
    import ebpc_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  dbp_block_t        dbp_block_i,
    input  logic              vld_i,
    output logic              rdy_o,
    input  logic              flush_i,
    bpc_coder_if.master       code_if,
    output logic              idle_o
);

    localparam logic [PLANE_IDX_W-1:0] LAST_PLANE = PLANE_IDX_W'(DATA_W);

    bpc_state_e             state_q, state_d;
    dbp_block_t             blk_q;
    logic [PLANE_IDX_W-1:0] plane_q;
    logic [RUN_CNT_W-1:0]   run_q;

    logic [PLANE_W-1:0]     dbp_cur;
    logic [PLANE_W-1:0]     dbp_prev;
    logic [PLANE_W-1:0]     dbx;
    logic                   dbx_zero;
    logic                   last_plane;
    bpc_code_t              plane_code;
    bpc_code_t              run_code;

    always_comb begin
        dbp_cur    = blk_q.dbp[plane_q];
        dbp_prev   = (plane_q == '0) ? '0 : blk_q.dbp[plane_q - PLANE_IDX_W'(1)];
        dbx        = dbp_cur ^ dbp_prev;
        dbx_zero   = (dbx == '0);
        last_plane = (plane_q == LAST_PLANE);
    end

    bpc_code_sel u_code_sel (
        .dbx        (dbx),
        .dbp        (dbp_cur),
        .run        (run_q),
        .plane_code (plane_code),
        .run_code   (run_code)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (vld_i) state_d = ST_BASE;
            ST_BASE: if (code_if.rdy) state_d = ST_SCAN;
            ST_SCAN: begin
                if (dbx_zero) begin
                    if (last_plane) state_d = ST_RUN;
                end else if (run_q == '0 && code_if.rdy && last_plane) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN:  if (code_if.rdy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A pending run is flushed before the plane that ended it, so the plane index holds until then.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blk_q   <= '0;
            plane_q <= '0;
            run_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (vld_i) begin
                        blk_q   <= dbp_block_i;
                        plane_q <= '0;
                        run_q   <= '0;
                    end
                end
                ST_SCAN: begin
                    if (dbx_zero) begin
                        run_q <= run_q + RUN_CNT_W'(1);
                        if (!last_plane) plane_q <= plane_q + PLANE_IDX_W'(1);
                    end else if (run_q != '0) begin
                        if (code_if.rdy) run_q <= '0;
                    end else if (code_if.rdy && !last_plane) begin
                        plane_q <= plane_q + PLANE_IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdy_o         = 1'b0;
        idle_o        = 1'b0;
        code_if.flush = 1'b0;
        code_if.vld   = 1'b0;
        code_if.data  = '0;
        code_if.len   = '0;
        case (state_q)
            ST_IDLE: begin
                rdy_o         = 1'b1;
                idle_o        = 1'b1;
                code_if.flush = flush_i & ~vld_i;
            end
            ST_BASE: begin
                code_if.vld  = 1'b1;
                code_if.data = BPC_CODE_W'(blk_q.base);
                code_if.len  = LEN_BASE;
            end
            ST_SCAN: begin
                if (!dbx_zero) begin
                    code_if.vld  = 1'b1;
                    code_if.data = (run_q != '0) ? run_code.data : plane_code.data;
                    code_if.len  = (run_q != '0) ? run_code.len  : plane_code.len;
                end
            end
            ST_RUN: begin
                code_if.vld  = 1'b1;
                code_if.data = run_code.data;
                code_if.len  = run_code.len;
            end
            default: ;
        endcase
    end

endmodule
